// File: rtl/alu_pkg.sv
// Shared definitions for the 16-bit execute-stage ALU: opcodes, condition-code
// bit positions, the shifter mode encoding and small decode helpers.
package alu_pkg;

  localparam int W = 16;

  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_SHL  = 4'b0101;
  localparam logic [3:0] OP_SHAR = 4'b0110;
  localparam logic [3:0] OP_SHLR = 4'b0111;
  localparam logic [3:0] OP_RL   = 4'b1000;
  localparam logic [3:0] OP_RR   = 4'b1001;
  localparam logic [3:0] OP_AND  = 4'b1011;
  localparam logic [3:0] OP_OR   = 4'b1100;
  localparam logic [3:0] OP_XOR  = 4'b1101;
  localparam logic [3:0] OP_NOT  = 4'b1110;
  localparam logic [3:0] OP_MUL  = 4'b1111;

  localparam int CC_C = 3;
  localparam int CC_V = 2;
  localparam int CC_N = 1;
  localparam int CC_Z = 0;

  typedef enum logic [2:0] {
    SH_SHL,
    SH_SHAR,
    SH_SHLR,
    SH_RL,
    SH_RR
  } shift_mode_e;

  // Non-shift opcodes map to SH_SHL; the shifter output is simply not selected.
  function automatic shift_mode_e shift_mode(input logic [3:0] op);
    shift_mode_e m;
    m = SH_SHL;
    case (op)
      OP_SHAR: m = SH_SHAR;
      OP_SHLR: m = SH_SHLR;
      OP_RL:   m = SH_RL;
      OP_RR:   m = SH_RR;
      default: m = SH_SHL;
    endcase
    return m;
  endfunction

  function automatic logic [3:0] pack_cc(input logic c, input logic v,
                                         input logic [W-1:0] r);
    logic [3:0] f;
    f       = '0;
    f[CC_C] = c;
    f[CC_V] = v;
    f[CC_N] = r[W-1];
    f[CC_Z] = (r == '0);
    return f;
  endfunction

endpackage

// File: rtl/alu_shifter.sv
// Combinational barrel shifter/rotator. Amount 0 passes the operand through
// with no carry or overflow.
module alu_shifter
  import alu_pkg::*;
(
  input  logic [W-1:0] a,
  input  logic [3:0]   amt,
  input  shift_mode_e  mode,
  output logic [W-1:0] y,
  output logic         c,
  output logic         v
);

  logic [2*W-1:0] shl_ext;
  logic [W:0]     shr_ext;
  logic [W:0]     sar_ext;
  logic [W-1:0]   rot_l;
  logic [W-1:0]   rot_r;
  logic [W-1:0]   out_mask;

  // Widened forms keep the bits that fall off the end, so carry comes for free.
  assign shl_ext  = {{W{1'b0}}, a} << amt;
  assign shr_ext  = {a, 1'b0} >> amt;
  assign sar_ext  = $signed({a, 1'b0}) >>> amt;
  assign rot_l    = (a << amt) | (a >> (5'd16 - {1'b0, amt}));
  assign rot_r    = (a >> amt) | (a << (5'd16 - {1'b0, amt}));
  assign out_mask = ~(16'hFFFF << amt);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // one unassigned; that is what keeps combinational blocks latch-free.
    y = a;
    c = 1'b0;
    v = 1'b0;
    case (mode)
      SH_SHL: begin
        y = shl_ext[W-1:0];
        c = shl_ext[W];
        // Overflow when any discarded bit disagrees with the new sign bit.
        v = |(shl_ext[2*W-1:W] ^ ({W{shl_ext[W-1]}} & out_mask));
      end
      SH_SHAR: begin
        y = sar_ext[W:1];
        c = sar_ext[0];
      end
      SH_SHLR: begin
        y = shr_ext[W:1];
        c = shr_ext[0];
      end
      SH_RL:   y = rot_l;
      SH_RR:   y = rot_r;
      default: y = a;
    endcase
  end

endmodule

// File: rtl/alu.sv
// 16-bit registered ALU: adder, multiplier, logic ops and the barrel shifter
// feed one result mux; result and condition codes register every cycle.
module alu
  import alu_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] valA,
  input  logic [W-1:0] valB,
  input  logic [3:0]   aluop,
  input  logic         sub,
  output logic [W-1:0] result,
  output logic [3:0]   cc
);

  logic           do_sub;
  logic [W-1:0]   b_eff;
  logic [W:0]     sum;
  logic           add_v;
  logic [2*W-1:0] prod;
  logic           mul_hi;

  logic [W-1:0]   sh_y;
  logic           sh_c;
  logic           sh_v;

  logic [W-1:0]   nxt_result;
  logic           nxt_c;
  logic           nxt_v;
  logic [3:0]     nxt_cc;

  // SUB always subtracts; ADD subtracts only when the sub control is set.
  assign do_sub = (aluop == OP_SUB) || ((aluop == OP_ADD) && sub);
  assign b_eff  = valB ^ {W{do_sub}};
  assign sum    = {1'b0, valA} + {1'b0, b_eff} + {{W{1'b0}}, do_sub};
  assign add_v  = (valA[W-1] == b_eff[W-1]) && (sum[W-1] != valA[W-1]);

  assign prod   = {{W{1'b0}}, valA} * {{W{1'b0}}, valB};
  assign mul_hi = |prod[2*W-1:W];

  alu_shifter u_shifter (
    .a    (valA),
    .amt  (valB[3:0]),
    .mode (shift_mode(aluop)),
    .y    (sh_y),
    .c    (sh_c),
    .v    (sh_v)
  );

  always_comb begin
    nxt_result = '0;
    nxt_c      = 1'b0;
    nxt_v      = 1'b0;
    case (aluop)
      OP_ADD, OP_SUB: begin
        nxt_result = sum[W-1:0];
        nxt_c      = sum[W];
        nxt_v      = add_v;
      end
      OP_MUL: begin
        nxt_result = prod[W-1:0];
        nxt_c      = mul_hi;
        nxt_v      = mul_hi;
      end
      OP_SHL, OP_SHAR, OP_SHLR: begin
        nxt_result = sh_y;
        nxt_c      = sh_c;
        nxt_v      = sh_v;
      end
      OP_RL, OP_RR: nxt_result = sh_y;
      OP_AND:       nxt_result = valA & valB;
      OP_OR:        nxt_result = valA | valB;
      OP_XOR:       nxt_result = valA ^ valB;
      // Logical NOT of B only; A never reaches the result.
      OP_NOT:       nxt_result = {{(W-1){1'b0}}, (valB == '0)};
      default:      nxt_result = '0;
    endcase
    nxt_cc = pack_cc(nxt_c, nxt_v, nxt_result);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments so every register samples pre-edge
    // values and updates together, independent of statement order.
    if (!rst_n) begin
      result <= '0;
      cc     <= '0;
    end else begin
      result <= nxt_result;
      cc     <= nxt_cc;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vectors per feature plus randomized
// back-to-back traffic against an arithmetic reference model.
module tb_alu;

  logic        clk;
  logic        rst_n;
  logic [15:0] valA;
  logic [15:0] valB;
  logic [3:0]  aluop;
  logic        sub;
  logic [15:0] result;
  logic [3:0]  cc;

  int checks = 0;
  int passed = 0;

  typedef struct {
    string       name;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  op;
    logic        s;
    logic [15:0] r;
    logic [3:0]  f;   // {C,V,N,Z}
  } vec_t;

  alu dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .valA   (valA),
    .valB   (valB),
    .aluop  (aluop),
    .sub    (sub),
    .result (result),
    .cc     (cc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input string name, input logic [15:0] a,
                              input logic [15:0] b, input logic [3:0] op,
                              input logic s, input logic [15:0] r,
                              input logic [3:0] f);
    vec_t v;
    v.name = name; v.a = a; v.b = b; v.op = op; v.s = s; v.r = r; v.f = f;
    return v;
  endfunction

  // Reference model from the arithmetic definitions; returns {result, C, V, N, Z}.
  function automatic logic [19:0] ref_alu(input logic [15:0] a, input logic [15:0] b,
                                          input logic [3:0] op, input logic s);
    logic [15:0] r;
    logic        c;
    logic        v;
    int          n;
    int          ua;
    int          ub;
    int          sa;
    int          sb;
    int          t;
    longint      p;
    r = 16'h0; c = 1'b0; v = 1'b0;
    n  = int'(b[3:0]);
    ua = int'({16'h0, a});
    ub = int'({16'h0, b});
    sa = int'($signed(a));
    sb = int'($signed(b));
    case (op)
      4'b0001, 4'b0010: begin
        if (op == 4'b0010 || s) begin
          t = ua - ub;
          r = t[15:0];
          c = (ua >= ub);
          t = sa - sb;
        end else begin
          t = ua + ub;
          r = t[15:0];
          c = (t > 65535);
          t = sa + sb;
        end
        v = (t > 32767) || (t < -32768);
      end
      4'b1111: begin
        p = longint'(ua) * longint'(ub);
        r = p[15:0];
        c = (p > 65535);
        v = c;
      end
      4'b0101: begin
        r = a << n;
        if (n > 0) c = a[16-n];
        for (int i = 16 - n; i < 16; i++)
          if (a[i] != r[15]) v = 1'b1;
      end
      4'b0110: begin
        r = a;
        for (int i = 0; i < n; i++) r = {r[15], r[15:1]};
        if (n > 0) c = a[n-1];
      end
      4'b0111: begin
        r = a;
        for (int i = 0; i < n; i++) r = {1'b0, r[15:1]};
        if (n > 0) c = a[n-1];
      end
      4'b1000: begin
        r = a;
        for (int i = 0; i < n; i++) r = {r[14:0], r[15]};
      end
      4'b1001: begin
        r = a;
        for (int i = 0; i < n; i++) r = {r[0], r[15:1]};
      end
      4'b1011: r = a & b;
      4'b1100: r = a | b;
      4'b1101: r = a ^ b;
      4'b1110: r = (b == 16'h0) ? 16'h0001 : 16'h0000;
      default: r = 16'h0;
    endcase
    return {r, c, v, r[15], (r == 16'h0)};
  endfunction

  task automatic apply(input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] op, input logic s);
    valA = a; valB = b; aluop = op; sub = s;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    valA = 16'($urandom()); valB = 16'($urandom());
    aluop = 4'($urandom()); sub = 1'($urandom());
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({result, cc} !== 20'h0)
      $display("FAIL reset_initial: got result=%h cc=%b want result=0000 cc=0000", result, cc);
    else passed++;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({result, cc} !== 20'h0)
      $display("FAIL reset_held: got result=%h cc=%b want result=0000 cc=0000", result, cc);
    else passed++;
    valA = 16'h1234; valB = 16'h0F0F; aluop = 4'b1100; sub = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({result, cc} !== {16'h1F3F, 4'b0000})
      $display("FAIL reset_release: got result=%h cc=%b want result=1f3f cc=0000", result, cc);
    else passed++;
  endtask

  task automatic test_async_reset();
    apply(16'hFF00, 16'h00FF, 4'b1100, 1'b0);
    // Mid-cycle reset must clear outputs before any further edge.
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({result, cc} !== 20'h0)
      $display("FAIL async_reset: got result=%h cc=%b want result=0000 cc=0000", result, cc);
    else passed++;
    valA = 16'd7; valB = 16'd9; aluop = 4'b0001; sub = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({result, cc} !== {16'd16, 4'b0000})
      $display("FAIL async_release: got result=%h cc=%b want result=0010 cc=0000", result, cc);
    else passed++;
  endtask

  task automatic test_addsub();
    vec_t v[$];
    v.push_back(mk("add_25000_30000", 16'd25000, 16'd30000, 4'b0001, 1'b0, 16'hD6D8, 4'b0110));
    v.push_back(mk("add_50000_50000", 16'd50000, 16'd50000, 4'b0001, 1'b0, 16'h86A0, 4'b1010));
    v.push_back(mk("sub_40000_20000", 16'd40000, 16'd20000, 4'b0010, 1'b1, 16'd20000, 4'b1100));
    v.push_back(mk("sub_20000_40000", 16'd20000, 16'd40000, 4'b0010, 1'b1, 16'hB1E0, 4'b0110));
    v.push_back(mk("sub_60000_60000", 16'd60000, 16'd60000, 4'b0010, 1'b1, 16'h0000, 4'b1001));
    v.push_back(mk("sub_ignores_ctl", 16'd40000, 16'd20000, 4'b0010, 1'b0, 16'd20000, 4'b1100));
    v.push_back(mk("add_with_sub",    16'd20000, 16'd40000, 4'b0001, 1'b1, 16'hB1E0, 4'b0110));
    foreach (v[i]) begin
      apply(v[i].a, v[i].b, v[i].op, v[i].s);
      checks++;
      if ({result, cc} !== {v[i].r, v[i].f})
        $display("FAIL %s: got result=%h cc=%b want result=%h cc=%b",
                 v[i].name, result, cc, v[i].r, v[i].f);
      else passed++;
    end
  endtask

  task automatic test_mul();
    vec_t v[$];
    v.push_back(mk("mul_100_200",   16'd100,   16'd200,   4'b1111, 1'b0, 16'd20000, 4'b0000));
    v.push_back(mk("mul_60000_sq",  16'd60000, 16'd60000, 4'b1111, 1'b0, 16'hA400,  4'b1110));
    v.push_back(mk("mul_by_zero",   16'd54321, 16'd0,     4'b1111, 1'b0, 16'h0000,  4'b0001));
    foreach (v[i]) begin
      apply(v[i].a, v[i].b, v[i].op, v[i].s);
      checks++;
      if ({result, cc} !== {v[i].r, v[i].f})
        $display("FAIL %s: got result=%h cc=%b want result=%h cc=%b",
                 v[i].name, result, cc, v[i].r, v[i].f);
      else passed++;
    end
  endtask

  task automatic test_shift();
    vec_t v[$];
    v.push_back(mk("shl_00ff_4",   16'h00FF, 16'h0004, 4'b0101, 1'b0, 16'h0FF0, 4'b0000));
    v.push_back(mk("shar_ff00_4",  16'hFF00, 16'h0004, 4'b0110, 1'b0, 16'hFFF0, 4'b0010));
    v.push_back(mk("shar_0fff_4",  16'h0FFF, 16'h0004, 4'b0110, 1'b0, 16'h00FF, 4'b1000));
    v.push_back(mk("shlr_ffff_15", 16'hFFFF, 16'h000F, 4'b0111, 1'b0, 16'h0001, 4'b1000));
    v.push_back(mk("rl_f0ff_4",    16'hF0FF, 16'h0004, 4'b1000, 1'b0, 16'h0FFF, 4'b0000));
    v.push_back(mk("rr_f0ff_4",    16'hF0FF, 16'h0004, 4'b1001, 1'b0, 16'hFF0F, 4'b0010));
    v.push_back(mk("shl_amt_0014", 16'h00FF, 16'h0014, 4'b0101, 1'b0, 16'h0FF0, 4'b0000));
    v.push_back(mk("shl_amt_zero", 16'h8001, 16'h0010, 4'b0101, 1'b0, 16'h8001, 4'b0010));
    v.push_back(mk("shl_overflow", 16'h4000, 16'h0001, 4'b0101, 1'b0, 16'h8000, 4'b0110));
    v.push_back(mk("shl_carry",    16'hC001, 16'h0001, 4'b0101, 1'b0, 16'h8002, 4'b1010));
    foreach (v[i]) begin
      apply(v[i].a, v[i].b, v[i].op, v[i].s);
      checks++;
      if ({result, cc} !== {v[i].r, v[i].f})
        $display("FAIL %s: got result=%h cc=%b want result=%h cc=%b",
                 v[i].name, result, cc, v[i].r, v[i].f);
      else passed++;
    end
  endtask

  task automatic test_logic();
    vec_t v[$];
    v.push_back(mk("and_zero",   16'hFF00, 16'h00FF, 4'b1011, 1'b0, 16'h0000, 4'b0001));
    v.push_back(mk("or_ones",    16'hFF00, 16'h00FF, 4'b1100, 1'b0, 16'hFFFF, 4'b0010));
    v.push_back(mk("xor",        16'hAAAA, 16'hAA55, 4'b1101, 1'b0, 16'h00FF, 4'b0000));
    v.push_back(mk("not_b1_ax",  16'hxxxx, 16'h0001, 4'b1110, 1'b0, 16'h0000, 4'b0001));
    v.push_back(mk("not_b0",     16'h5A5A, 16'h0000, 4'b1110, 1'b0, 16'h0001, 4'b0000));
    v.push_back(mk("unused_0011", 16'h1234, 16'h5678, 4'b0011, 1'b1, 16'h0000, 4'b0001));
    v.push_back(mk("unused_1010", 16'hFFFF, 16'hFFFF, 4'b1010, 1'b0, 16'h0000, 4'b0001));
    foreach (v[i]) begin
      apply(v[i].a, v[i].b, v[i].op, v[i].s);
      checks++;
      if ({result, cc} !== {v[i].r, v[i].f})
        $display("FAIL %s: got result=%h cc=%b want result=%h cc=%b",
                 v[i].name, result, cc, v[i].r, v[i].f);
      else passed++;
    end
  endtask

  // A new random operation every cycle, each checked against the model.
  task automatic test_back_to_back();
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  op;
    logic        s;
    logic [19:0] exp;
    for (int k = 0; k < 600; k++) begin
      a  = 16'($urandom());
      b  = 16'($urandom());
      op = 4'($urandom());
      s  = 1'($urandom());
      if (k % 4 == 0) a = 16'($urandom_range(0, 255));
      if (k % 5 == 0) b = 16'($urandom_range(0, 31));
      exp = ref_alu(a, b, op, s);
      apply(a, b, op, s);
      checks++;
      if ({result, cc} !== exp)
        $display("FAIL rand_%0d op=%b a=%h b=%h sub=%b: got result=%h cc=%b want result=%h cc=%b",
                 k, op, a, b, s, result, cc, exp[19:4], exp[3:0]);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_addsub();
    test_mul();
    test_shift();
    test_logic();
    test_async_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/alu.md
# alu

16-bit registered arithmetic/logic unit for the datapath execute stage. Each cycle it takes two operands and a 4-bit opcode, computes add, subtract, multiply, shift, rotate or logic results, and registers a 16-bit result with a 4-bit condition-code vector.

## Interface
- Parameters: none. Width is fixed at 16 bits.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; asynchronous, active-low.
- valA  input  16  operand A (first/shifted operand).
- valB  input  16  operand B (second operand / shift-rotate amount).
- aluop  input  4  operation select.
- sub  input  1  subtract control for the adder.
- result  output  16  registered result.
- cc  output  4  registered flags: cc[3]=C (carry), cc[2]=V (overflow), cc[1]=N (result[15]), cc[0]=Z (result==0).

## Operation
- Opcodes:
  - 0001 ADD: A+B, or A−B when sub=1.
  - 0010 SUB: A−B regardless of sub.
  - 0101 SHL: A << B[3:0].
  - 0110 SHAR: arithmetic shift right, A >>> B[3:0].
  - 0111 SHLR: logical shift right, A >> B[3:0].
  - 1000 RL: rotate A left by B[3:0].
  - 1001 RR: rotate A right by B[3:0].
  - 1011 AND, 1100 OR, 1101 XOR: bitwise A op B.
  - 1110 NOT: logical NOT of B. Result is 0x0001 if B==0, else 0x0000. A is ignored, including X.
  - 1111 MUL: unsigned A×B, low 16 bits.
- Adder: A + (B ^ {16{s}}) + s, where s is the subtract control. Result is sum[15:0].
  - C = carry out of bit 15. For subtract, C=1 means no borrow.
  - V = signed two's-complement overflow.
- MUL: full 32-bit unsigned product. C = V = 1 iff product[31:16] != 0.
- Shift amount is B[3:0] only; B[15:4] is ignored. Amount 0 passes A through with C=0.
- SHL flags:
  - C = last bit shifted out.
  - V = 1 if any discarded bit differs from the resulting result[15].
- SHAR and SHLR flags: C = last bit shifted out (A[amt−1]); V=0.
- Rotates and logic ops: C=0, V=0.
- N and Z are always derived from the final 16-bit result.
- Unused opcodes (0000, 0011, 0100, 1010): result 0x0000, C=V=N=0, Z=1.

## Timing
- Fully synchronous, single-cycle latency. Inputs are sampled at a rising clk edge; result and cc reflect them after that same edge.
- result and cc update every cycle. There is no enable or handshake, and a new operation may be issued every cycle.
- Reset: rst_n low immediately forces result=0x0000 and cc=4'b0000, independent of clk.
- Reset asserted mid-stream discards the in-flight operation.
- The first edge after rst_n deasserts captures the current inputs.
- All compute logic is combinational between the input sample and the output registers. There is no multicycle path; the multiplier must close in one cycle.

## Structure
- Shared package alu_pkg holds:
  - the opcode localparams (OP_ADD…OP_MUL);
  - the cc bit-index constants (CC_C=3, CC_V=2, CC_N=1, CC_Z=0).
- One sub-module, alu_shifter: a combinational barrel shifter/rotator taking A, a 4-bit amount and the mode (SHL/SHAR/SHLR/RL/RR), returning the result plus shifted-out carry and overflow.
- Adder, multiplier, logic ops, flag generation and output registers live in alu.

## Test plan
- Reset: drive rst_n low with random inputs -> result=0, cc=0 without a clock edge. After release, the next edge shows the current operation.
- ADD, sub=0:
  - 25000+30000 -> 55000 (0xD6D8), C=0, V=1, N=1, Z=0.
  - 50000+50000 -> 0x86A0, C=1, V=0, N=1.
- SUB, sub=1:
  - 40000−20000 -> 20000, C=1.
  - 20000−40000 -> 0xB1E0, N=1, C=0.
  - 60000−60000 -> 0, Z=1, C=1.
  - ADD with sub=1 behaves identically to SUB.
- MUL:
  - 100×200 -> 20000, C=V=0.
  - 60000×60000 -> 0xA400, C=V=1.
  - 54321×0 -> 0, Z=1.
- Shift/rotate:
  - SHL 0x00FF by 4 -> 0x0FF0, V=0.
  - SHAR 0xFF00 by 4 -> 0xFFF0, N=1.
  - SHAR 0x0FFF by 4 -> 0x00FF.
  - SHLR 0xFFFF by 15 -> 0x0001, C=1.
  - RL 0xF0FF by 4 -> 0x0FFF.
  - RR 0xF0FF by 4 -> 0xFF0F.
  - B=0x0014 shifts by 4.
- Logic:
  - AND 0xFF00,0x00FF -> 0, Z=1.
  - OR -> 0xFFFF, N=1.
  - XOR 0xAAAA,0xAA55 -> 0x00FF.
  - NOT with A=X, B=1 -> 0, Z=1.
  - NOT with B=0 -> 0x0001.
  - Opcode 0011 -> 0, Z=1.
